// File: rtl/forward_hazard_if.sv
// Decode-side hazard bus between the pipeline control and forward_hazard_unit.
// Optional macro: FWD_HAZARD_PERF_EN adds the stall_cnt performance counter.
interface forward_hazard_if;
    localparam int unsigned REG_W = 5;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned CNT_W = 32;

    logic             id_valid;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [REG_W-1:0] id_rd;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             flush_ex;
    logic             pipe_hold;
    logic             stall_id;
    logic [SEL_W-1:0] fwd_sel_A;
    logic [SEL_W-1:0] fwd_sel_B;
`ifdef FWD_HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    // Pipeline control side: presents the decode instruction, consumes hazard decisions
    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output id_rd, id_reg_write, id_mem_read, flush_ex, pipe_hold,
        input  stall_id, fwd_sel_A, fwd_sel_B
`ifdef FWD_HAZARD_PERF_EN
        , input stall_cnt
`endif
    );

    // Hazard unit side
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  id_rd, id_reg_write, id_mem_read, flush_ex, pipe_hold,
        output stall_id, fwd_sel_A, fwd_sel_B
`ifdef FWD_HAZARD_PERF_EN
        , output stall_cnt
`endif
    );
endinterface

// File: rtl/forward_hazard_unit.sv
// Load-use stall detection and EX operand forwarding selection for a 5-stage pipe.
// Tracks EX/MEM/WB stage records internally; forwarding is decoded from those
// records only. Optional macro: FWD_HAZARD_PERF_EN adds a saturating stall counter.
module forward_hazard_unit (
    input  logic             clk,
    input  logic             reset_n,
    forward_hazard_if.slave  hz
);
    localparam int unsigned REG_W = 5;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned CNT_W = 32;

    localparam logic [SEL_W-1:0] SEL_RF  = 2'b00;
    localparam logic [SEL_W-1:0] SEL_WB  = 2'b01;
    localparam logic [SEL_W-1:0] SEL_MEM = 2'b10;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             use_rs1;
        logic             use_rs2;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic             mem_read;
    } ex_rec_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             reg_write;
    } wr_rec_t;

    ex_rec_t ex_q,  ex_d;
    wr_rec_t mem_q, mem_d;
    wr_rec_t wb_q,  wb_d;
    logic    stall_c;

    // True when a later stage will write a non-x0 register that this source reads
    function automatic logic produces(input wr_rec_t w, input logic use_rs,
                                      input logic [REG_W-1:0] rs);
        return w.valid && w.reg_write && (w.rd != '0) && use_rs && (w.rd == rs);
    endfunction

    // Youngest producer wins; a bubble in EX never forwards
    function automatic logic [SEL_W-1:0] pick(input logic ex_valid, input logic use_rs,
                                              input logic [REG_W-1:0] rs,
                                              input wr_rec_t m, input wr_rec_t w);
        if (!ex_valid)                 return SEL_RF;
        else if (produces(m, use_rs, rs)) return SEL_MEM;
        else if (produces(w, use_rs, rs)) return SEL_WB;
        else                           return SEL_RF;
    endfunction

    // Load-use detection against the instruction currently in EX; a flush kills it
    always_comb begin
        stall_c = 1'b0;
        if (!hz.flush_ex && hz.id_valid && ex_q.valid && ex_q.mem_read &&
            ex_q.reg_write && (ex_q.rd != '0)) begin
            stall_c = (hz.id_use_rs1 && (hz.id_rs1 == ex_q.rd)) ||
                      (hz.id_use_rs2 && (hz.id_rs2 == ex_q.rd));
        end
    end

    // Record advance: hold freezes everything, stall/flush inject an EX bubble
    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!hz.pipe_hold) begin
            wb_d            = mem_q;
            mem_d.valid     = ex_q.valid;
            mem_d.rd        = ex_q.rd;
            mem_d.reg_write = ex_q.reg_write;
            if (hz.flush_ex || stall_c) begin
                ex_d = '0;
            end else begin
                ex_d.valid     = hz.id_valid;
                ex_d.rs1       = hz.id_rs1;
                ex_d.rs2       = hz.id_rs2;
                ex_d.use_rs1   = hz.id_use_rs1;
                ex_d.use_rs2   = hz.id_use_rs2;
                ex_d.rd        = hz.id_rd;
                ex_d.reg_write = hz.id_reg_write;
                ex_d.mem_read  = hz.id_mem_read;
            end
        end
    end

    // Stage record registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign hz.stall_id  = stall_c;
    assign hz.fwd_sel_A = pick(ex_q.valid, ex_q.use_rs1, ex_q.rs1, mem_q, wb_q);
    assign hz.fwd_sel_B = pick(ex_q.valid, ex_q.use_rs2, ex_q.rs2, mem_q, wb_q);

`ifdef FWD_HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Count stall cycles that actually inject a bubble, saturating at all-ones
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_c && !hz.pipe_hold && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Stall counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stall_cnt_q <= '0;
        else          stall_cnt_q <= stall_cnt_d;
    end

    assign hz.stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit: forwarding, load-use stall, flush, hold, reset.
// Optional macro: FWD_HAZARD_PERF_EN enables the stall counter check.
module tb_forward_hazard_unit;
    logic clk;
    logic reset_n;
    int   tests;
    int   fails;

    forward_hazard_if hz();

    forward_hazard_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic rw, input logic mr);
        hz.id_valid     = v;
        hz.id_rs1       = rs1;
        hz.id_rs2       = rs2;
        hz.id_use_rs1   = u1;
        hz.id_use_rs2   = u2;
        hz.id_rd        = rd;
        hz.id_reg_write = rw;
        hz.id_mem_read  = mr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        nop();
        repeat (3) tick();
    endtask

    task automatic chk_sel(input string tag, input logic [1:0] a, input logic [1:0] b);
        chk({tag, "_selA"}, 32'(hz.fwd_sel_A), 32'(a));
        chk({tag, "_selB"}, 32'(hz.fwd_sel_B), 32'(b));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset_n      = 1'b0;
        hz.flush_ex  = 1'b0;
        hz.pipe_hold = 1'b0;
        nop();
        #3;
        chk("reset_stall", 32'(hz.stall_id), 32'd0);
        chk_sel("reset", 2'b00, 2'b00);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // add x5 ; sub rs2=x5 -> EX/MEM forward on B
        set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
        tick();
        set_id(1, 5'd3, 5'd5, 1, 1, 5'd6, 1, 0);
        chk("s1_nostall", 32'(hz.stall_id), 32'd0);
        tick();
        chk_sel("s1_exmem", 2'b00, 2'b10);
        nop();
        tick();
        chk_sel("s1_bubble", 2'b00, 2'b00);
        drain();

        // producer x5 ; unrelated ; consumer rs1=x5 -> MEM/WB forward on A
        set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
        tick();
        set_id(1, 5'd1, 5'd2, 1, 1, 5'd8, 1, 0);
        tick();
        set_id(1, 5'd5, 5'd9, 1, 1, 5'd10, 1, 0);
        tick();
        chk_sel("s2_memwb", 2'b01, 2'b00);
        drain();

        // lw x7 ; add rs2=x7 -> one stall cycle, bubble, then MEM/WB forward
        set_id(1, 5'd2, 5'd0, 1, 0, 5'd7, 1, 1);
        tick();
        set_id(1, 5'd1, 5'd7, 1, 1, 5'd9, 1, 0);
        chk("s3_stall_on", 32'(hz.stall_id), 32'd1);
        tick();
        chk("s3_stall_off", 32'(hz.stall_id), 32'd0);
        chk_sel("s3_bubble", 2'b00, 2'b00);
        tick();
        chk_sel("s3_after", 2'b00, 2'b01);
        drain();

        // x5 written by both MEM and WB instructions -> youngest (MEM) wins
        set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
        tick();
        set_id(1, 5'd1, 5'd3, 1, 1, 5'd5, 1, 0);
        tick();
        set_id(1, 5'd4, 5'd5, 1, 1, 5'd11, 1, 0);
        tick();
        chk_sel("s4_both", 2'b00, 2'b10);
        drain();

        // load into x0 ; consumer rs1=rs2=x0 -> no stall, no forward
        set_id(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1);
        tick();
        set_id(1, 5'd0, 5'd0, 1, 1, 5'd12, 1, 0);
        chk("s5_x0_nostall", 32'(hz.stall_id), 32'd0);
        tick();
        chk_sel("s5_x0", 2'b00, 2'b00);
        drain();

        // load-use with flush -> no stall, EX bubble, lw still advances
        set_id(1, 5'd2, 5'd0, 1, 0, 5'd7, 1, 1);
        tick();
        set_id(1, 5'd1, 5'd7, 1, 1, 5'd9, 1, 0);
        hz.flush_ex = 1'b1;
        #1;
        chk("s6_flush_nostall", 32'(hz.stall_id), 32'd0);
        tick();
        hz.flush_ex = 1'b0;
        set_id(1, 5'd7, 5'd0, 1, 0, 5'd13, 1, 0);
        chk_sel("s6_bubble", 2'b00, 2'b00);
        tick();
        chk_sel("s6_lw_in_wb", 2'b01, 2'b00);
        drain();

        // hold 3 cycles: selects stable, records frozen
        set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
        tick();
        set_id(1, 5'd3, 5'd5, 1, 1, 5'd6, 1, 0);
        tick();
        chk_sel("s7_pre", 2'b00, 2'b10);
        hz.pipe_hold = 1'b1;
        set_id(1, 5'd5, 5'd0, 1, 0, 5'd14, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_sel($sformatf("s7_hold%0d", i), 2'b00, 2'b10);
        end
        hz.pipe_hold = 1'b0;
        #1;
        tick();
        chk_sel("s7_release", 2'b01, 2'b00);
        drain();

        // load-use under hold: stall held, bubble deferred to release
        set_id(1, 5'd2, 5'd0, 1, 0, 5'd7, 1, 1);
        tick();
        set_id(1, 5'd1, 5'd7, 1, 1, 5'd9, 1, 0);
        hz.pipe_hold = 1'b1;
        #1;
        tick();
        chk("s7b_hold_stall", 32'(hz.stall_id), 32'd1);
        hz.pipe_hold = 1'b0;
        #1;
        tick();
        chk("s7b_release_stall", 32'(hz.stall_id), 32'd0);
        drain();

`ifdef FWD_HAZARD_PERF_EN
        chk("perf_cnt", hz.stall_cnt, 32'd2);
`endif

        // reset pulse mid-stall clears everything asynchronously
        set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
        tick();
        set_id(1, 5'd5, 5'd0, 1, 0, 5'd7, 1, 1);
        tick();
        set_id(1, 5'd1, 5'd7, 1, 1, 5'd9, 1, 0);
        chk("s8_stall_pre", 32'(hz.stall_id), 32'd1);
        chk_sel("s8_pre", 2'b10, 2'b00);
        reset_n = 1'b0;
        #1;
        chk("s8_rst_stall", 32'(hz.stall_id), 32'd0);
        chk_sel("s8_rst", 2'b00, 2'b00);
`ifdef FWD_HAZARD_PERF_EN
        chk("s8_rst_cnt", hz.stall_cnt, 32'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("s8_post_nostall", 32'(hz.stall_id), 32'd0);
        tick();
        set_id(1, 5'd9, 5'd0, 1, 0, 5'd15, 1, 0);
        tick();
        chk_sel("s8_accept", 2'b10, 2'b00);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/forward_hazard_unit.md
FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock; reset_n  in  1  asynchronous active-low reset.
REQ-002 The block SHALL have these inputs:
- id_valid  in  1  decode-stage instruction valid.
- id_rs1, id_rs2  in  5 each  decode source registers.
- id_use_rs1, id_use_rs2  in  1 each  source actually read.
- id_rd  in  5  decode destination.
- id_reg_write  in  1  decode instruction writes rd.
- id_mem_read  in  1  decode instruction is a load.
- flush_ex  in  1  branch mispredict: kill the instruction entering EX.
- pipe_hold  in  1  global freeze, e.g. memory wait.
REQ-003 The block SHALL have these outputs:
- stall_id  out  1  load-use stall request to IF/ID.
- fwd_sel_A  out  2  operand-A forwarding select for the EX instruction.
- fwd_sel_B  out  2  operand-B forwarding select for the EX instruction.
REQ-004 The select encoding SHALL be: 00 register file, 01 MEM/WB result, 10 EX/MEM result; 11 SHALL never be driven.

Function
REQ-005 The block SHALL keep internal stage records: EX (valid, rs1, rs2, use flags, rd, reg_write, mem_read), MEM (valid, rd, reg_write) and WB (valid, rd, reg_write).
REQ-006 Each rising edge with pipe_hold=0 SHALL advance the records ID->EX->MEM->WB.
REQ-007 pipe_hold=1 SHALL freeze all records; flush_ex and the stall bubble SHALL have no effect during hold.
REQ-008 stall_id SHALL be combinational: id_valid & EX.valid & EX.mem_read & EX.reg_write & EX.rd!=0 & ((id_use_rs1 & id_rs1==EX.rd) | (id_use_rs2 & id_rs2==EX.rd)).
REQ-009 stall_id SHALL be forced 0 when flush_ex=1.
REQ-010 When stall_id=1 and pipe_hold=0, the block SHALL load a bubble (valid=0, reg_write=0) into EX while MEM and WB advance normally; the stall SHALL last exactly one cycle per load-use pair.
REQ-011 When flush_ex=1 and pipe_hold=0, the block SHALL load a bubble into EX regardless of the ID contents.
REQ-012 fwd_sel_B SHALL be 10 when MEM.valid & MEM.reg_write & MEM.rd!=0 & EX.use_rs2 & MEM.rd==EX.rs2.
REQ-013 Otherwise fwd_sel_B SHALL be 01 when the same condition holds against WB.
REQ-014 Otherwise fwd_sel_B SHALL be 00.
REQ-015 fwd_sel_A SHALL follow REQ-012..014 using EX.rs1 and EX.use_rs1.
REQ-016 When MEM and WB both match, MEM (10) SHALL win, so the youngest producer is forwarded.
REQ-017 Register x0 SHALL never be forwarded or cause a stall.
REQ-018 Forwarding selects SHALL depend only on stage records (registered state), with no combinational path from id_* inputs.
REQ-019 A bubble in EX SHALL drive fwd_sel_A = fwd_sel_B = 00.

Reset
REQ-020 reset_n=0 SHALL immediately clear all stage valid, reg_write and mem_read bits and set every rd/rs field to 0.
REQ-021 During reset, stall_id SHALL be 0 and fwd_sel_A = fwd_sel_B = 00.
REQ-022 Reset asserted mid-stall SHALL cancel the stall; the first edge after deassertion SHALL accept ID normally.

Configuration
REQ-023 With FWD_HAZARD_PERF_EN defined, the block SHALL add output stall_cnt (32 bits), reset to 0, incrementing on each edge where stall_id=1 and pipe_hold=0, and saturating at 0xFFFFFFFF.
REQ-024 Without FWD_HAZARD_PERF_EN, the stall_cnt port and its counter SHALL not exist.
REQ-025 The setting of FWD_HAZARD_PERF_EN SHALL not change any other behaviour.

Verification
REQ-026 The bench SHALL cover these scenarios:
- add x5 followed by sub using rs2=x5 -> fwd_sel_B=10 in the sub's EX cycle.
- Producer of x5, an unrelated instruction, then a consumer of x5 in rs1 -> fwd_sel_A=01.
- lw x7 then add rs2=x7 -> stall_id=1 for exactly one cycle, an EX bubble, then fwd_sel_B=01.
- x5 written by both the MEM and WB instructions, consumer rs2=x5 -> fwd_sel_B=10.
- Producer rd=x0, consumer rs1=rs2=x0 -> both selects 00, stall_id=0.
- Load-use with flush_ex=1 -> stall_id=0 and an EX bubble.
- Hold for 3 cycles -> selects stable and no record movement.
- With FWD_HAZARD_PERF_EN defined -> stall_cnt counts 2 after two load-use pairs.
- Reset pulse mid-stall -> all outputs 0 asynchronously.
